// File: rtl/tournament_predictor.sv
// Tournament branch predictor: PC-indexed local table, gshare global table and a
// chooser, swept to weakly-not-taken after reset, with a repairable speculative GHR.
module tournament_predictor #(
    parameter int IDX_W = 10,
    parameter int GHR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             fetch_br,
    output logic             p_outcome,
    output logic             g_p_outcome,
    output logic             l_p_outcome,
    output logic [IDX_W-1:0] l_p_idx,
    output logic [IDX_W-1:0] g_p_idx,
    output logic [IDX_W-1:0] p_idx,
    input  logic             upd_valid,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_l_idx,
    input  logic [IDX_W-1:0] upd_g_idx,
    input  logic [IDX_W-1:0] upd_p_idx,
    input  logic             upd_g_outcome,
    input  logic             upd_l_outcome,
    output logic             ready,
    output logic [GHR_W-1:0] ghr
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_cnt;
    logic [1:0]       l_tab [DEPTH];
    logic [1:0]       g_tab [DEPTH];
    logic [1:0]       c_tab [DEPTH];
    logic [IDX_W-1:0] repair_hist;
    logic             unused_bits;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        if (up)
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    always_comb begin
        l_p_idx     = pc[IDX_W+1:2];
        p_idx       = pc[IDX_W+1:2];
        g_p_idx     = pc[IDX_W+1:2] ^ ghr;
        l_p_outcome = ready & l_tab[l_p_idx][1];
        g_p_outcome = ready & g_tab[g_p_idx][1];
        p_outcome   = ready & (c_tab[p_idx][1] ? g_tab[g_p_idx][1] : l_tab[l_p_idx][1]);
    end

    // History as it stood when the mispredicted branch was looked up.
    assign repair_hist = upd_g_idx ^ upd_pc[IDX_W+1:2];
    assign unused_bits = ^{pc[31:IDX_W+2], pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0],
                           repair_hist[IDX_W-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
            ready     <= 1'b0;
            ghr       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (upd_valid && upd_mispredict)
                        ghr <= {repair_hist[GHR_W-2:0], upd_taken};
                    else if (fetch_br)
                        ghr <= {ghr[GHR_W-2:0], p_outcome};
                end
                default: state <= INIT;
            endcase
        end
    end

    // NOTE: the tables carry no reset; the INIT sweep gives every entry a defined value.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            l_tab[sweep_cnt] <= 2'b01;
            g_tab[sweep_cnt] <= 2'b01;
            c_tab[sweep_cnt] <= 2'b01;
        end else if (upd_valid) begin
            l_tab[upd_l_idx] <= sat_step(l_tab[upd_l_idx], upd_taken);
            g_tab[upd_g_idx] <= sat_step(g_tab[upd_g_idx], upd_taken);
            if (upd_g_outcome != upd_l_outcome)
                c_tab[upd_p_idx] <= sat_step(c_tab[upd_p_idx], upd_g_outcome == upd_taken);
        end
    end

endmodule
